// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution PE controller and its sorter.
package conv_pkg;

   localparam int DEF_NUM_VALS    = 4;
   localparam int DEF_PIXEL_SIZE  = 8;
   localparam int DEF_KERNEL_SIZE = 11;

   typedef enum logic [1:0] {
      LOAD,
      SORT,
      RUN
   } conv_ctrl_state_e;

   // Coefficients are sign-magnitude; ordering only ever looks at magnitude.
   function automatic logic [DEF_KERNEL_SIZE-2:0] coef_mag(input logic [DEF_KERNEL_SIZE-1:0] coef);
      return coef[DEF_KERNEL_SIZE-2:0];
   endfunction

endpackage

// File: rtl/coef_sorter.sv
// One odd-even transposition layer over the coefficient slots and their index tags.
module coef_sorter
   import conv_pkg::*;
#(
   parameter int NUM_VALS    = DEF_NUM_VALS,
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
)(
   input  logic                        phase,
   input  logic [KERNEL_SIZE-1:0]      slot_in  [NUM_VALS],
   input  logic [$clog2(NUM_VALS)-1:0] tag_in   [NUM_VALS],
   output logic [KERNEL_SIZE-1:0]      slot_out [NUM_VALS],
   output logic [$clog2(NUM_VALS)-1:0] tag_out  [NUM_VALS]
);

   // Pairs are disjoint within a layer, so each swap reads only unmodified inputs.
   // Strict greater-than keeps equal magnitudes in load order.
   always_comb begin
      slot_out = slot_in;
      tag_out  = tag_in;
      for (int i = 0; i < NUM_VALS - 1; i++) begin
         if ((i[0] == phase) &&
             (slot_in[i][KERNEL_SIZE-2:0] > slot_in[i+1][KERNEL_SIZE-2:0])) begin
            slot_out[i]   = slot_in[i+1];
            slot_out[i+1] = slot_in[i];
            tag_out[i]    = tag_in[i+1];
            tag_out[i+1]  = tag_in[i];
         end
      end
   end

endmodule

// File: rtl/conv_pe_ctrl.sv
// Loads and magnitude-sorts a coefficient set for the convolution PE, then
// streams pixels through it with a two-stage valid/ready pipeline.
module conv_pe_ctrl
   import conv_pkg::*;
#(
   parameter int NUM_VALS    = DEF_NUM_VALS,
   parameter int PIXEL_SIZE  = DEF_PIXEL_SIZE,
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [KERNEL_SIZE-1:0]      cfg_coef,
   input  logic                        pix_valid,
   output logic                        pix_ready,
   input  logic [PIXEL_SIZE-1:0]       pix_data,
   output logic [PIXEL_SIZE-1:0]       pe_a,
   output logic [KERNEL_SIZE-1:0]      pe_kernel [NUM_VALS],
   output logic [$clog2(NUM_VALS)-1:0] pe_sel    [NUM_VALS],
   input  logic [PIXEL_SIZE-1:0]       pe_result [NUM_VALS],
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [PIXEL_SIZE-1:0]       out_data  [NUM_VALS],
   output logic                        kernel_ok
);

   localparam int SEL_W = $clog2(NUM_VALS);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_VALS - 1);

   conv_ctrl_state_e       state_q, state_d;
   logic [SEL_W-1:0]       cnt_q, cnt_d;
   logic                   cfg_ready_q, cfg_ready_d;
   logic [KERNEL_SIZE-1:0] slot_q [NUM_VALS];
   logic [KERNEL_SIZE-1:0] slot_d [NUM_VALS];
   logic [SEL_W-1:0]       tag_q  [NUM_VALS];
   logic [SEL_W-1:0]       tag_d  [NUM_VALS];
   logic [KERNEL_SIZE-1:0] sort_slot [NUM_VALS];
   logic [SEL_W-1:0]       sort_tag  [NUM_VALS];
   logic [PIXEL_SIZE-1:0]  pe_a_q, pe_a_d;
   logic                   s1_valid_q, s1_valid_d;
   logic                   out_valid_q, out_valid_d;
   logic [PIXEL_SIZE-1:0]  out_data_q [NUM_VALS];
   logic [PIXEL_SIZE-1:0]  out_data_d [NUM_VALS];
   logic                   cfg_fire;
   logic                   s1_adv;
   logic                   pix_rdy;
   logic                   pix_fire;

   coef_sorter #(
      .NUM_VALS    (NUM_VALS),
      .KERNEL_SIZE (KERNEL_SIZE)
   ) u_sorter (
      .phase    (cnt_q[0]),
      .slot_in  (slot_q),
      .tag_in   (tag_q),
      .slot_out (sort_slot),
      .tag_out  (sort_tag)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      slot_d      = slot_q;
      tag_d       = tag_q;
      pe_a_d      = pe_a_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      cfg_fire = cfg_valid & cfg_ready_q;
      s1_adv   = s1_valid_q & (~out_valid_q | out_ready);
      // A pending reconfiguration blocks new pixels so the pipeline can drain.
      pix_rdy  = (state_q == RUN) & ~cfg_valid & (~s1_valid_q | s1_adv);
      pix_fire = pix_valid & pix_rdy;

      case (state_q)
         LOAD: begin
            if (cfg_fire) begin
               slot_d[cnt_q] = cfg_coef;
               tag_d[cnt_q]  = cnt_q;
               if (cnt_q == LAST_IDX) begin
                  state_d = SORT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + SEL_W'(1);
               end
            end
         end
         SORT: begin
            slot_d = sort_slot;
            tag_d  = sort_tag;
            if (cnt_q == LAST_IDX) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + SEL_W'(1);
            end
         end
         RUN: begin
            if (cfg_valid && !s1_valid_q && !out_valid_q) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = LOAD;
            cnt_d   = '0;
         end
      endcase

      if (pix_fire) begin
         pe_a_d = pix_data;
      end
      s1_valid_d = pix_fire | (s1_valid_q & ~s1_adv);

      if (s1_adv) begin
         out_data_d  = pe_result;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      cfg_ready_d = (state_d == LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LOAD;
         cnt_q       <= '0;
         cfg_ready_q <= 1'b0;
         pe_a_q      <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < NUM_VALS; i++) begin
            slot_q[i]     <= '0;
            tag_q[i]      <= SEL_W'(i);
            out_data_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cfg_ready_q <= cfg_ready_d;
         pe_a_q      <= pe_a_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         slot_q      <= slot_d;
         tag_q       <= tag_d;
         out_data_q  <= out_data_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign pix_ready = pix_rdy;
   assign pe_a      = pe_a_q;
   assign pe_kernel = slot_q;
   assign pe_sel    = tag_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign kernel_ok = (state_q == RUN);

endmodule

// File: tb/tb_conv_pe_ctrl.sv
// Directed bench for conv_pe_ctrl with a simple behavioural PE in the loop.
module tb_conv_pe_ctrl;

   logic        clk;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [10:0] cfg_coef;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  pix_data;
   logic [7:0]  pe_a;
   logic [10:0] pe_kernel [4];
   logic [1:0]  pe_sel    [4];
   logic [7:0]  pe_result [4];
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data  [4];
   logic        kernel_ok;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   logic [10:0] ka [4];
   logic [1:0]  sa [4];
   logic [10:0] kb [4];
   logic [1:0]  sb [4];

   logic [31:0] rx_q   [$];
   int          rx_cyc [$];
   logic        hold_chk_en = 1'b0;
   logic        held = 1'b0;
   logic [31:0] held_data;
   logic [31:0] out_pack;

   conv_pe_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_coef  (cfg_coef),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_data  (pix_data),
      .pe_a      (pe_a),
      .pe_kernel (pe_kernel),
      .pe_sel    (pe_sel),
      .pe_result (pe_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .kernel_ok (kernel_ok)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stand-in PE: any function of pixel, coefficient and original index will do.
   function automatic logic [7:0] pe_f(input logic [7:0] a, input logic [10:0] k, input logic [1:0] s);
      logic [15:0] prod;
      prod = {8'd0, a} * {8'd0, k[7:0]};
      return prod[7:0] + {6'd0, s};
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) pe_result[i] = pe_f(pe_a, pe_kernel[i], pe_sel[i]);
   end

   function automatic logic [31:0] exp_res(input logic [7:0] p, input bit setb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = setb ? pe_f(p, kb[i], sb[i]) : pe_f(p, ka[i], sa[i]);
      return r;
   endfunction

   assign out_pack = {out_data[3], out_data[2], out_data[1], out_data[0]};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (out_valid && out_ready) begin
         rx_q.push_back(out_pack);
         rx_cyc.push_back(cyc);
      end
      if (hold_chk_en) begin
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_pack !== held_data)
               $display("FAIL hold_stable: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_pack, held_data);
            else passed++;
         end
         held      <= out_valid && !out_ready;
         held_data <= out_pack;
      end else begin
         held <= 1'b0;
      end
   end

   task automatic load_word(input logic [10:0] c);
      int bound;
      bound = 0;
      cfg_valid = 1'b1;
      cfg_coef  = c;
      while (cfg_ready !== 1'b1 && bound < 100) begin
         @(negedge clk);
         bound++;
      end
      if (bound >= 100) begin
         checks++;
         $display("FAIL load_timeout: cfg_ready got %b expected 1", cfg_ready);
      end
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cfg_valid = 1'b0; cfg_coef = '0; pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
      @(negedge clk);
      checks++; if (cfg_ready !== 1'b0) $display("FAIL rst_cfg_ready: got %b expected 0", cfg_ready); else passed++;
      checks++; if (pix_ready !== 1'b0) $display("FAIL rst_pix_ready: got %b expected 0", pix_ready); else passed++;
      checks++; if (out_valid !== 1'b0 || kernel_ok !== 1'b0)
         $display("FAIL rst_flags: got out_valid=%b kernel_ok=%b expected 0 0", out_valid, kernel_ok); else passed++;
      checks++; if (pe_a !== 8'd0 || out_pack !== 32'd0)
         $display("FAIL rst_data: got pe_a=%h out=%h expected 0 0", pe_a, out_pack); else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pe_kernel[i] !== 11'd0 || pe_sel[i] !== 2'(i))
            $display("FAIL rst_kernel_sel[%0d]: got k=%h s=%0d expected k=0 s=%0d", i, pe_kernel[i], pe_sel[i], i);
         else passed++;
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (cfg_ready !== 1'b0) $display("FAIL rst_release_cfg_ready: got %b expected 0", cfg_ready); else passed++;
      @(negedge clk);
      checks++; if (cfg_ready !== 1'b1) $display("FAIL idle_cfg_ready: got %b expected 1", cfg_ready); else passed++;
      checks++; if (pix_ready !== 1'b0) $display("FAIL idle_pix_ready: got %b expected 0", pix_ready); else passed++;
   endtask

   task automatic test_sort;
      load_word(11'h12C);
      load_word(11'h40C);
      load_word(11'h200);
      load_word(11'h00C);
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (kernel_ok !== 1'b0 || pix_ready !== 1'b0 || cfg_ready !== 1'b0)
            $display("FAIL sort_busy[%0d]: got ok=%b pix_rdy=%b cfg_rdy=%b expected 0 0 0", j, kernel_ok, pix_ready, cfg_ready);
         else passed++;
         @(negedge clk);
      end
      checks++;
      if (kernel_ok !== 1'b1 || pix_ready !== 1'b1)
         $display("FAIL sort_done: got ok=%b pix_rdy=%b expected 1 1", kernel_ok, pix_ready);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pe_kernel[i] !== ka[i] || pe_sel[i] !== sa[i])
            $display("FAIL sort_set_a[%0d]: got k=%h s=%0d expected k=%h s=%0d", i, pe_kernel[i], pe_sel[i], ka[i], sa[i]);
         else passed++;
      end
   endtask

   task automatic test_stream;
      int first_acc;
      rx_q.delete(); rx_cyc.delete();
      out_ready = 1'b1;
      first_acc = 0;
      for (int p = 1; p <= 10; p++) begin
         pix_valid = 1'b1;
         pix_data  = p[7:0];
         #1;
         checks++; if (pix_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b expected 1", p, pix_ready); else passed++;
         if (p == 1) first_acc = cyc;
         @(negedge clk);
         if (p == 1) begin
            checks++; if (pe_a !== 8'd1) $display("FAIL stream_pe_a: got %h expected 01", pe_a); else passed++;
         end
      end
      pix_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (rx_q.size() != 10) $display("FAIL stream_count: got %0d expected 10", rx_q.size()); else passed++;
      for (int k = 0; k < rx_q.size() && k < 10; k++) begin
         checks++;
         if (rx_q[k] !== exp_res(8'(k + 1), 1'b0) || rx_cyc[k] != first_acc + 2 + k)
            $display("FAIL stream_out[%0d]: got %h @%0d expected %h @%0d", k, rx_q[k], rx_cyc[k],
                     exp_res(8'(k + 1), 1'b0), first_acc + 2 + k);
         else passed++;
      end
   endtask

   task automatic test_backpressure;
      int p;
      int bound;
      rx_q.delete(); rx_cyc.delete();
      hold_chk_en = 1'b1;
      p = 20;
      bound = 0;
      while (p < 28 && bound < 200) begin
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         pix_valid = 1'b1;
         pix_data  = p[7:0];
         #1;
         if (pix_ready) p++;
         @(negedge clk);
         bound++;
      end
      if (bound >= 200) begin
         checks++;
         $display("FAIL bp_timeout: got %0d pixels expected 8", p - 20);
      end
      pix_valid = 1'b0;
      repeat (30) begin
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         @(negedge clk);
      end
      hold_chk_en = 1'b0;
      out_ready = 1'b1;
      checks++; if (rx_q.size() != 8) $display("FAIL bp_count: got %0d expected 8", rx_q.size()); else passed++;
      for (int k = 0; k < rx_q.size() && k < 8; k++) begin
         checks++;
         if (rx_q[k] !== exp_res(8'(20 + k), 1'b0))
            $display("FAIL bp_out[%0d]: got %h expected %h", k, rx_q[k], exp_res(8'(20 + k), 1'b0));
         else passed++;
      end
   endtask

   task automatic test_reconfig;
      rx_q.delete(); rx_cyc.delete();
      out_ready = 1'b1;
      for (int p = 1; p <= 3; p++) begin
         pix_valid = 1'b1;
         pix_data  = p[7:0];
         @(negedge clk);
      end
      cfg_valid = 1'b1;
      cfg_coef  = 11'h005;
      pix_data  = 8'd99;
      #1;
      checks++; if (pix_ready !== 1'b0) $display("FAIL reconf_pix_ready: got %b expected 0", pix_ready); else passed++;
      load_word(11'h005);
      load_word(11'h403);
      load_word(11'h001);
      load_word(11'h004);
      pix_valid = 1'b0;
      checks++; if (rx_q.size() != 3) $display("FAIL reconf_drain_count: got %0d expected 3", rx_q.size()); else passed++;
      for (int k = 0; k < rx_q.size() && k < 3; k++) begin
         checks++;
         if (rx_q[k] !== exp_res(8'(k + 1), 1'b0))
            $display("FAIL reconf_drain[%0d]: got %h expected %h", k, rx_q[k], exp_res(8'(k + 1), 1'b0));
         else passed++;
      end
      repeat (4) @(negedge clk);
      checks++; if (kernel_ok !== 1'b1) $display("FAIL reconf_ok: got %b expected 1", kernel_ok); else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pe_kernel[i] !== kb[i] || pe_sel[i] !== sb[i])
            $display("FAIL reconf_set_b[%0d]: got k=%h s=%0d expected k=%h s=%0d", i, pe_kernel[i], pe_sel[i], kb[i], sb[i]);
         else passed++;
      end
      for (int p = 5; p <= 6; p++) begin
         pix_valid = 1'b1;
         pix_data  = p[7:0];
         @(negedge clk);
      end
      pix_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (rx_q.size() != 5) $display("FAIL reconf_count: got %0d expected 5", rx_q.size()); else passed++;
      for (int k = 3; k < rx_q.size() && k < 5; k++) begin
         checks++;
         if (rx_q[k] !== exp_res(8'(k + 2), 1'b1))
            $display("FAIL reconf_out[%0d]: got %h expected %h", k, rx_q[k], exp_res(8'(k + 2), 1'b1));
         else passed++;
      end
   endtask

   task automatic test_reset_mid;
      int bound;
      out_ready = 1'b0;
      for (int p = 7; p <= 8; p++) begin
         bound = 0;
         pix_valid = 1'b1;
         pix_data  = p[7:0];
         #1;
         while (pix_ready !== 1'b1 && bound < 20) begin
            @(negedge clk);
            #1;
            bound++;
         end
         @(negedge clk);
      end
      pix_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || pe_a !== 8'd8)
         $display("FAIL mid_full: got out_valid=%b pe_a=%h expected 1 08", out_valid, pe_a); else passed++;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || kernel_ok !== 1'b0 || pix_ready !== 1'b0 || cfg_ready !== 1'b0)
         $display("FAIL mid_rst_flags: got ov=%b ok=%b pr=%b cr=%b expected 0 0 0 0", out_valid, kernel_ok, pix_ready, cfg_ready);
      else passed++;
      checks++; if (pe_a !== 8'd0 || out_pack !== 32'd0)
         $display("FAIL mid_rst_data: got pe_a=%h out=%h expected 0 0", pe_a, out_pack); else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pe_kernel[i] !== 11'd0 || pe_sel[i] !== 2'(i))
            $display("FAIL mid_rst_kernel[%0d]: got k=%h s=%0d expected k=0 s=%0d", i, pe_kernel[i], pe_sel[i], i);
         else passed++;
      end
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      load_word(11'h005);
      load_word(11'h403);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (pe_kernel[0] !== 11'd0 || pe_kernel[1] !== 11'd0 || cfg_ready !== 1'b0)
         $display("FAIL load_rst: got k0=%h k1=%h cr=%b expected 0 0 0", pe_kernel[0], pe_kernel[1], cfg_ready);
      else passed++;
      rst = 1'b0;
      @(negedge clk);
      load_word(11'h005);
      load_word(11'h403);
      repeat (6) @(negedge clk);
      checks++; if (kernel_ok !== 1'b0 || cfg_ready !== 1'b1)
         $display("FAIL partial_load: got ok=%b cr=%b expected 0 1", kernel_ok, cfg_ready); else passed++;
      load_word(11'h001);
      load_word(11'h004);
      repeat (4) @(negedge clk);
      checks++; if (kernel_ok !== 1'b1) $display("FAIL fresh_load_ok: got %b expected 1", kernel_ok); else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pe_kernel[i] !== kb[i] || pe_sel[i] !== sb[i])
            $display("FAIL fresh_load_set[%0d]: got k=%h s=%0d expected k=%h s=%0d", i, pe_kernel[i], pe_sel[i], kb[i], sb[i]);
         else passed++;
      end
   endtask

   initial begin
      // Set A magnitudes 300,12,512,12 -> sorted 12(1),12(3),300(0),512(2).
      ka[0] = 11'h40C; ka[1] = 11'h00C; ka[2] = 11'h12C; ka[3] = 11'h200;
      sa[0] = 2'd1;    sa[1] = 2'd3;    sa[2] = 2'd0;    sa[3] = 2'd2;
      // Set B magnitudes 5,3,1,4 -> sorted 1(2),3(1),4(3),5(0).
      kb[0] = 11'h001; kb[1] = 11'h403; kb[2] = 11'h004; kb[3] = 11'h005;
      sb[0] = 2'd2;    sb[1] = 2'd1;    sb[2] = 2'd3;    sb[3] = 2'd0;

      test_reset;
      test_sort;
      test_stream;
      test_backpressure;
      test_reconfig;
      test_reset_mid;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
